// File: rtl/secded_decoder_pipe.sv
// Two-stage pipelined SECDED decoder behind valid/ready streams.
// Stage 1 registers the codeword with its syndrome and parity; stage 2 registers the corrected payload.
module secded_decoder_pipe #(
  parameter int M = 32,
  parameter int CNT_W = 16,
  // Fixed-point iteration of r = clog2(M + r + 1). It starts below the solution,
  // so it settles on the smallest r that satisfies 2^r >= M + r + 1.
  localparam int R0 = $clog2(M + 1),
  localparam int R1 = $clog2(M + 1 + R0),
  localparam int R = $clog2(M + 1 + R1),
  localparam int N = M + R + 1,
  localparam int EW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [M-1:0]     out_data,
  output logic             out_sec,
  output logic             out_ded,
  output logic [EW-1:0]    out_err_pos,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sec_cnt,
  output logic [CNT_W-1:0] ded_cnt
);

  function automatic logic [N-1:0] syn_mask(input int k);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N - 1; i++) begin
      if ((((i + 1) >> k) & 1) != 0) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Codeword index of payload bit j: the j-th index below N-1 whose (index+1) is not a power of two.
  function automatic int data_idx(input int j);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int i = 0; i < N - 1; i++) begin
      if (((i + 1) & i) != 0) begin
        if (cnt == j) res = i;
        cnt++;
      end
    end
    return res;
  endfunction

  logic             adv1;
  logic             adv2;
  logic [R-1:0]     syn_next;
  logic             par_next;

  logic             s1_valid_reg;
  logic [N-1:0]     s1_code_reg;
  logic [R-1:0]     s1_syn_reg;
  logic             s1_par_reg;

  logic             s2_valid_reg;
  logic [M-1:0]     data_reg;
  logic             sec_reg;
  logic             ded_reg;
  logic [EW-1:0]    pos_reg;

  logic [N-1:0]     corr_next;
  logic [M-1:0]     data_next;
  logic             sec_next;
  logic             ded_next;
  logic [EW-1:0]    pos_next;

  logic [CNT_W-1:0] sec_cnt_reg;
  logic [CNT_W-1:0] ded_cnt_reg;
  logic             deliver;

  assign adv2     = !s2_valid_reg || out_ready;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;
  assign deliver  = s2_valid_reg && out_ready;

  generate
    for (genvar gi = 0; gi < R; gi++) begin : g_syn
      localparam logic [N-1:0] MASK = syn_mask(gi);
      assign syn_next[gi] = ^(in_data & MASK);
    end
  endgenerate

  assign par_next = ^in_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_code_reg  <= '0;
      s1_syn_reg   <= '0;
      s1_par_reg   <= 1'b0;
    end else if (adv1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_code_reg <= in_data;
        s1_syn_reg  <= syn_next;
        s1_par_reg  <= par_next;
      end
    end
  end

  always_comb begin
    corr_next = s1_code_reg;
    sec_next  = 1'b0;
    ded_next  = 1'b0;
    pos_next  = '0;
    if (s1_par_reg) begin
      if (s1_syn_reg == '0) begin
        // Only the overall parity bit is wrong; the payload is untouched.
        sec_next = 1'b1;
        pos_next = EW'(N - 1);
      end else if (s1_syn_reg <= R'(N - 1)) begin
        sec_next = 1'b1;
        pos_next = EW'(s1_syn_reg - 1'b1);
        corr_next[pos_next] = ~s1_code_reg[pos_next];
      end else begin
        ded_next = 1'b1;
      end
    end else if (s1_syn_reg != '0) begin
      ded_next = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < M; gi++) begin : g_extract
      localparam int DIDX = data_idx(gi);
      assign data_next[gi] = corr_next[DIDX];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      data_reg     <= '0;
      sec_reg      <= 1'b0;
      ded_reg      <= 1'b0;
      pos_reg      <= '0;
    end else if (adv2) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        data_reg <= data_next;
        sec_reg  <= sec_next;
        ded_reg  <= ded_next;
        pos_reg  <= pos_next;
      end
    end
  end

  // Clear takes priority over a coincident increment.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      sec_cnt_reg <= '0;
      ded_cnt_reg <= '0;
    end else if (deliver) begin
      if (sec_reg && (sec_cnt_reg != '1)) sec_cnt_reg <= sec_cnt_reg + 1'b1;
      if (ded_reg && (ded_cnt_reg != '1)) ded_cnt_reg <= ded_cnt_reg + 1'b1;
    end
  end

  assign out_valid   = s2_valid_reg;
  assign out_data    = data_reg;
  assign out_sec     = sec_reg;
  assign out_ded     = ded_reg;
  assign out_err_pos = pos_reg;
  assign sec_cnt     = sec_cnt_reg;
  assign ded_cnt     = ded_cnt_reg;

endmodule

// File: tb/tb_secded_decoder_pipe.sv
// Directed bench for secded_decoder_pipe (M = 32, N = 39, CNT_W = 2).
// Each scenario task drives its own stimulus and checks against hand-computed values.
module tb_secded_decoder_pipe;
  localparam int M = 32;
  localparam int N = 39;
  localparam int EW = 6;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [M-1:0]     out_data;
  logic             out_sec;
  logic             out_ded;
  logic [EW-1:0]    out_err_pos;
  logic             cnt_clr = 1'b0;
  logic [CNT_W-1:0] sec_cnt;
  logic [CNT_W-1:0] ded_cnt;

  int tests = 0;
  int fails = 0;

  secded_decoder_pipe #(.M(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .out_err_pos(out_err_pos),
    .cnt_clr(cnt_clr), .sec_cnt(sec_cnt), .ded_cnt(ded_cnt)
  );

  always #5 clk = ~clk;

  // Sends one word with out_ready high and returns at the negedge where its result is on out_*.
  task automatic apply(input logic [N-1:0] code);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = code;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] word in=%h valid=%0b data=%h sec=%0b ded=%0b pos=%0d", code, out_valid, out_data,
             out_sec, out_ded, out_err_pos);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    tests++; if (out_data !== 32'h0 || out_sec !== 1'b0 || out_ded !== 1'b0 || out_err_pos !== 6'd0) begin
      fails++; $display("FAIL reset_outs got=%h/%0b/%0b/%0d exp=0/0/0/0", out_data, out_sec, out_ded, out_err_pos);
    end
    tests++; if (sec_cnt !== 2'd0 || ded_cnt !== 2'd0) begin
      fails++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", sec_cnt, ded_cnt);
    end
  endtask

  task automatic test_clean();
    apply(39'h0);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL clean_valid got=%0b exp=1", out_valid); end
    tests++; if (out_data !== 32'h0 || out_sec !== 1'b0 || out_ded !== 1'b0) begin
      fails++; $display("FAIL clean_out got=%h/%0b/%0b exp=0/0/0", out_data, out_sec, out_ded);
    end
  endtask

  task automatic test_single();
    apply(39'h20);
    tests++; if (out_data !== 32'h0 || out_sec !== 1'b1 || out_ded !== 1'b0 || out_err_pos !== 6'd5) begin
      fails++; $display("FAIL single5 got=%h/%0b/%0b/%0d exp=0/1/0/5", out_data, out_sec, out_ded, out_err_pos);
    end
    @(negedge clk);
    tests++; if (sec_cnt !== 2'd1) begin fails++; $display("FAIL single5_cnt got=%0d exp=1", sec_cnt); end
  endtask

  task automatic test_overall_parity();
    apply(39'h40_0000_0000);
    tests++; if (out_data !== 32'h0 || out_sec !== 1'b1 || out_ded !== 1'b0 || out_err_pos !== 6'd38) begin
      fails++; $display("FAIL single38 got=%h/%0b/%0b/%0d exp=0/1/0/38", out_data, out_sec, out_ded, out_err_pos);
    end
    @(negedge clk);
    tests++; if (sec_cnt !== 2'd2) begin fails++; $display("FAIL single38_cnt got=%0d exp=2", sec_cnt); end
  endtask

  task automatic test_double();
    apply(39'h14);
    tests++; if (out_data !== 32'h3 || out_sec !== 1'b0 || out_ded !== 1'b1 || out_err_pos !== 6'd0) begin
      fails++; $display("FAIL double got=%h/%0b/%0b/%0d exp=3/0/1/0", out_data, out_sec, out_ded, out_err_pos);
    end
    @(negedge clk);
    tests++; if (ded_cnt !== 2'd1) begin fails++; $display("FAIL double_cnt got=%0d exp=1", ded_cnt); end
  endtask

  task automatic test_triple();
    apply(39'h00_8000_8080);
    tests++; if (out_data !== 32'h0 || out_sec !== 1'b0 || out_ded !== 1'b1 || out_err_pos !== 6'd0) begin
      fails++; $display("FAIL triple got=%h/%0b/%0b/%0d exp=0/0/1/0", out_data, out_sec, out_ded, out_err_pos);
    end
  endtask

  task automatic test_data_words();
    apply(39'h40_0000_0007);
    tests++; if (out_data !== 32'h1 || out_sec !== 1'b0 || out_ded !== 1'b0) begin
      fails++; $display("FAIL data_d0 got=%h/%0b/%0b exp=1/0/0", out_data, out_sec, out_ded);
    end
    apply(39'h20_8000_000A);
    tests++; if (out_data !== 32'h8000_0000 || out_sec !== 1'b0 || out_ded !== 1'b0) begin
      fails++; $display("FAIL data_d31 got=%h/%0b/%0b exp=80000000/0/0", out_data, out_sec, out_ded);
    end
    apply(39'h40_0000_0003);
    tests++; if (out_data !== 32'h1 || out_sec !== 1'b1 || out_err_pos !== 6'd2) begin
      fails++; $display("FAIL data_fix2 got=%h/%0b/%0d exp=1/1/2", out_data, out_sec, out_err_pos);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] words [4];
    logic [M-1:0] exp_data [4];
    logic         exp_sec [4];
    int sent;
    int rcvd;
    words[0] = 39'h0;            exp_data[0] = 32'h0;         exp_sec[0] = 1'b0;
    words[1] = 39'h40_0000_0007; exp_data[1] = 32'h1;         exp_sec[1] = 1'b0;
    words[2] = 39'h20_8000_000A; exp_data[2] = 32'h8000_0000; exp_sec[2] = 1'b0;
    words[3] = 39'h40_0000_0003; exp_data[3] = 32'h1;         exp_sec[3] = 1'b1;
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 4);
      in_data   = words[(sent < 4) ? sent : 0];
      #1;
      if (cyc == 2 || cyc == 3) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready cyc=%0d got=%0b exp=0", cyc, in_ready); end
        tests++; if (out_valid !== 1'b1 || out_data !== exp_data[0]) begin
          fails++; $display("FAIL stall_hold cyc=%0d got=%0b/%h exp=1/%h", cyc, out_valid, out_data, exp_data[0]);
        end
      end
      if (out_valid && out_ready) begin
        $display("[TB] stream out #%0d data=%h sec=%0b", rcvd, out_data, out_sec);
        if (rcvd < 4) begin
          tests++; if (out_data !== exp_data[rcvd] || out_sec !== exp_sec[rcvd]) begin
            fails++; $display("FAIL stream_order idx=%0d got=%h/%0b exp=%h/%0b", rcvd, out_data, out_sec,
                              exp_data[rcvd], exp_sec[rcvd]);
          end
        end
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    tests++; if (rcvd !== 4) begin fails++; $display("FAIL stream_count got=%0d exp=4", rcvd); end
  endtask

  task automatic test_counters();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    tests++; if (sec_cnt !== 2'd0 || ded_cnt !== 2'd0) begin
      fails++; $display("FAIL cnt_clear got=%0d/%0d exp=0/0", sec_cnt, ded_cnt);
    end
    for (int i = 0; i < 5; i++) apply(39'h20);
    @(negedge clk);
    tests++; if (sec_cnt !== 2'd3) begin fails++; $display("FAIL cnt_saturate got=%0d exp=3", sec_cnt); end
    apply(39'h20);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    tests++; if (sec_cnt !== 2'd0) begin fails++; $display("FAIL cnt_clr_wins got=%0d exp=0", sec_cnt); end
  endtask

  task automatic test_reset_midstream();
    int seen;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 39'h20;
    @(negedge clk);
    in_data = 39'h40_0000_0007;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sec !== 1'b0) begin
      fails++; $display("FAIL midrst_flush got=%0b/%h/%0b exp=0/0/0", out_valid, out_data, out_sec);
    end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready got=%0b exp=1", in_ready); end
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) seen++;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midrst_no_delivery got=%0d exp=0", seen); end
    tests++; if (sec_cnt !== 2'd0) begin fails++; $display("FAIL midrst_cnt got=%0d exp=0", sec_cnt); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single();
    test_overall_parity();
    test_double();
    test_triple();
    test_data_words();
    test_back_to_back();
    test_counters();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
